// File: rtl/fifo_pkg.sv
// Shared defaults for the fifo block: data/address widths, status thresholds
// and derived depth.
package fifo_pkg;

  localparam int FIFO_DATA_W        = 8;
  localparam int FIFO_ADDR_W        = 3;
  localparam int FIFO_PART_EMPTY_TH = 2;
  localparam int FIFO_PART_FULL_TH  = 6;
  localparam int FIFO_DEPTH         = 1 << FIFO_ADDR_W;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage array with one synchronous write port and one
// registered read port. The array itself is not reset; only the read register is.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value between accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO with occupancy count and empty/full/part flags.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W        = FIFO_DATA_W,
  parameter int ADDR_W        = FIFO_ADDR_W,
  parameter int PART_EMPTY_TH = FIFO_PART_EMPTY_TH,
  parameter int PART_FULL_TH  = FIFO_PART_FULL_TH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] out,
  output logic              empty,
  output logic              full,
  output logic              part_empt,
  output logic              part_full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output logic [ADDR_W:0]   fifo_counter
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(1 << ADDR_W);
  localparam logic [CNT_W-1:0] PE_TH_C = CNT_W'(PART_EMPTY_TH);
  localparam logic [CNT_W-1:0] PF_TH_C = CNT_W'(PART_FULL_TH);

  // Handshake: a request (wr_en / rd_en) is a one-cycle strobe; it is taken on
  // the rising edge only when the FIFO can serve it (!full / !empty), otherwise
  // it is dropped with no retry and no state change.
  logic              wr_ok;
  logic              rd_ok;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  assign empty     = (fifo_counter == '0);
  assign full      = (fifo_counter == DEPTH_C);
  assign part_empt = (fifo_counter <= PE_TH_C);
  assign part_full = (fifo_counter >= PF_TH_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_counter <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   fifo_counter <= fifo_counter + CNT_W'(1);
        2'b01:   fifo_counter <= fifo_counter - CNT_W'(1);
        default: fifo_counter <= fifo_counter;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`endif

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (in),
    .re    (rd_ok),
    .raddr (rd_ptr),
    .rdata (out)
  );

endmodule

// File: tb/tb_fifo.sv
// Directed + random bench for fifo with a queue-based reference model and
// scoreboard of expected read data.
module tb_fifo;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int PE_TH = 2;
  localparam int PF_TH = 6;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] out;
  logic          empty;
  logic          full;
  logic          part_empt;
  logic          part_full;
  logic [AW:0]   fifo_counter;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  fifo dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .out          (out),
    .empty        (empty),
    .full         (full),
    .part_empt    (part_empt),
    .part_full    (part_full),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .fifo_counter (fifo_counter)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model and scoreboard
  logic [DW-1:0] mdl_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_out;
  logic          mdl_ovf;
  logic          mdl_udf;
  int            vec_cnt;
  int            err_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    int sz;
    sz = mdl_q.size();
    check({tag, ":count"},     32'(fifo_counter), 32'(sz));
    check({tag, ":empty"},     32'(empty),        32'(sz == 0));
    check({tag, ":full"},      32'(full),         32'(sz == DEPTH));
    check({tag, ":part_empt"}, 32'(part_empt),    32'(sz <= PE_TH));
    check({tag, ":part_full"}, 32'(part_full),    32'(sz >= PF_TH));
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, ":overflow"},  32'(overflow),     32'(mdl_ovf));
    check({tag, ":underflow"}, 32'(underflow),    32'(mdl_udf));
`endif
  endtask

  // driver: one clock cycle of stimulus, then update model and compare
  task automatic step(input string tag, input logic wr, input logic rd, input logic [DW-1:0] d);
    logic wr_ok;
    logic rd_ok;
    wr_en = wr;
    rd_en = rd;
    in    = d;
    wr_ok = wr && (mdl_q.size() < DEPTH);
    rd_ok = rd && (mdl_q.size() > 0);
    if (wr && !wr_ok) mdl_ovf = 1'b1;
    if (rd && !rd_ok) mdl_udf = 1'b1;
    @(posedge clk);
    #1;
    if (rd_ok) exp_q.push_back(mdl_q.pop_front());
    if (wr_ok) mdl_q.push_back(d);
    if (exp_q.size() > 0) last_out = exp_q.pop_front();
    check({tag, ":out"}, 32'(out), 32'(last_out));
    check_status(tag);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic model_reset();
    mdl_q.delete();
    exp_q.delete();
    last_out = '0;
    mdl_ovf  = 1'b0;
    mdl_udf  = 1'b0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    in    = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("reset:out", 32'(out), 32'(0));
    check_status("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // single push/pop
    step("push1", 1'b1, 1'b0, 8'd1);
    step("pop1",  1'b0, 1'b1, 8'd0);

    // simultaneous read/write with one entry
    step("push11", 1'b1, 1'b0, 8'h11);
    step("rw2",    1'b1, 1'b1, 8'd2);
    step("pop2",   1'b0, 1'b1, 8'd0);

    // fill past full: 10..130, last five dropped
    for (int i = 1; i <= 13; i++) step("fill", 1'b1, 1'b0, 8'(i * 10));
    check("fill:full_held", 32'(full), 32'(1));

    // drain with one pop/push across the wrap
    for (int i = 0; i < 4; i++) step("drain_a", 1'b0, 1'b1, 8'd0);
    step("drain_rw", 1'b1, 1'b1, 8'hAA);
    for (int i = 0; i < 4; i++) step("drain_b", 1'b0, 1'b1, 8'd0);
    check("drain:empty", 32'(empty), 32'(1));

    // pop while empty, then overflow and full read/write
    step("pop_empty", 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 8; i++) step("refill", 1'b1, 1'b0, 8'(8'h40 + i));
    step("push_full", 1'b1, 1'b0, 8'hEE);
    step("rw_full",   1'b1, 1'b1, 8'hEF);
    for (int i = 0; i < 8; i++) step("empty_out", 1'b0, 1'b1, 8'd0);

    // random traffic
    for (int i = 0; i < 60; i++)
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

    // asynchronous reset with 5 entries
    while (mdl_q.size() > 0) step("pre_rst_drain", 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 5; i++) step("pre_rst_fill", 1'b1, 1'b0, 8'(8'h90 + i));
    step("pre_rst_pop", 1'b0, 1'b1, 8'd0);
    step("pre_rst_push", 1'b1, 1'b0, 8'h9F);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_rst:out", 32'(out), 32'(0));
    check_status("async_rst");
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst_push", 1'b1, 1'b0, 8'd5);
    step("post_rst_pop",  1'b0, 1'b1, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
